// File: rtl/prim_assembler_if.sv
// Vertex-in / triangle-out bundle between the register decoder, the primitive assembler and the rasterizer.
interface prim_assembler_if #(
  parameter int X_W       = 16,
  parameter int Y_W       = 16,
  parameter int Z_W       = 25,
  parameter int COLOR_W   = 32,
  parameter int UV_W      = 32,
  parameter int OUT_DEPTH = 4
);
  localparam int POS_W = X_W + Y_W + Z_W;
  localparam int VTX_W = POS_W + COLOR_W + UV_W;
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);

  logic               color_we;
  logic [COLOR_W-1:0] color_data;
  logic               uv_we;
  logic [UV_W-1:0]    uv_data;
  logic               mode_we;
  logic [1:0]         mode_data;
  logic               restart;
  logic               vtx_valid;
  logic               vtx_ready;
  logic [POS_W-1:0]   vtx_pos;
  logic               tri_valid;
  logic               tri_ready;
  logic [3*VTX_W-1:0] tri_vtx;
  logic [1:0]         vtx_count;
  logic [CNT_W-1:0]   out_count;
  logic               busy;

  modport master (
    output color_we, color_data, uv_we, uv_data, mode_we, mode_data, restart,
    output vtx_valid, vtx_pos, tri_ready,
    input  vtx_ready, tri_valid, tri_vtx, vtx_count, out_count, busy
  );

  modport slave (
    input  color_we, color_data, uv_we, uv_data, mode_we, mode_data, restart,
    input  vtx_valid, vtx_pos, tri_ready,
    output vtx_ready, tri_valid, tri_vtx, vtx_count, out_count, busy
  );
endinterface

// File: rtl/prim_assembler.sv
// Assembles LIST/STRIP/FAN triangles from decoded vertex writes into an OUT_DEPTH FIFO; tri_valid 1 cycle after the completing vertex.
// vtx_ready drops while the FIFO is full (registered occupancy); the rasterizer side is valid/ready.
module prim_assembler #(
  parameter int X_W       = 16,
  parameter int Y_W       = 16,
  parameter int Z_W       = 25,
  parameter int COLOR_W   = 32,
  parameter int UV_W      = 32,
  parameter int OUT_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  prim_assembler_if.slave  bus
);
  localparam int POS_W = X_W + Y_W + Z_W;
  localparam int VTX_W = POS_W + COLOR_W + UV_W;
  localparam int TRI_W = 3 * VTX_W;
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);
  localparam int PTR_W = $clog2(OUT_DEPTH);

  typedef enum logic [1:0] {
    MODE_LIST  = 2'd0,
    MODE_STRIP = 2'd1,
    MODE_FAN   = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  mode_e              mode;
  logic [COLOR_W-1:0] cur_color;
  logic [UV_W-1:0]    cur_uv;
  logic [VTX_W-1:0]   h0;
  logic [VTX_W-1:0]   h1;
  logic [1:0]         vtx_cnt;
  logic               parity;

  logic [TRI_W-1:0]   fifo_mem [OUT_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   fifo_cnt;

  logic               accept;
  logic               restart_any;
  logic               completes;
  logic               pop;
  logic [VTX_W-1:0]   new_vtx;
  logic [TRI_W-1:0]   new_tri;

  assign bus.vtx_ready = (fifo_cnt != CNT_W'(OUT_DEPTH));
  assign accept        = bus.vtx_valid && bus.vtx_ready;
  assign restart_any   = bus.restart || bus.mode_we;
  assign completes     = accept && !restart_any && (vtx_cnt == 2'd2);
  assign pop           = (fifo_cnt != '0) && bus.tri_ready;

  // Colour/UV are the values registered before this edge, so a same-cycle write affects the next vertex.
  assign new_vtx = {cur_uv, cur_color, bus.vtx_pos};
  // Odd strip triangles swap the held pair to keep a consistent winding.
  assign new_tri = (mode == MODE_STRIP && parity) ? {new_vtx, h0, h1} : {new_vtx, h1, h0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_color <= '1;
      cur_uv    <= '0;
      mode      <= MODE_LIST;
      vtx_cnt   <= 2'd0;
      parity    <= 1'b0;
      h0        <= '0;
      h1        <= '0;
    end else begin
      if (bus.color_we) cur_color <= bus.color_data;
      if (bus.uv_we)    cur_uv    <= bus.uv_data;
      if (bus.mode_we)  mode      <= mode_e'(bus.mode_data);

      if (restart_any) begin
        parity  <= 1'b0;
        vtx_cnt <= accept ? 2'd1 : 2'd0;
        if (accept) h0 <= new_vtx;
      end else if (accept) begin
        if (vtx_cnt == 2'd2) begin
          case (mode)
            MODE_STRIP: begin
              h0     <= h1;
              h1     <= new_vtx;
              parity <= ~parity;
            end
            MODE_FAN: h1 <= new_vtx;
            default:  vtx_cnt <= 2'd0;
          endcase
        end else begin
          if (vtx_cnt[0]) h1 <= new_vtx;
          else            h0 <= new_vtx;
          vtx_cnt <= vtx_cnt + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (completes) begin
        fifo_mem[wr_ptr] <= new_tri;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({completes, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign bus.tri_valid = (fifo_cnt != '0);
  assign bus.tri_vtx   = fifo_mem[rd_ptr];
  assign bus.vtx_count = vtx_cnt;
  assign bus.out_count = fifo_cnt;
  assign bus.busy      = (vtx_cnt != 2'd0) || (fifo_cnt != '0);
endmodule

// File: tb/tb_prim_assembler.sv
// Directed bench for prim_assembler: list-based reference model checked every cycle plus literal spot checks.
module tb_prim_assembler;
  localparam int POS_W     = 57;
  localparam int VTX_W     = 121;
  localparam int TRI_W     = 363;
  localparam int OUT_DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prim_assembler_if bus ();
  prim_assembler dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic [VTX_W-1:0] vlist [$];
  logic [TRI_W-1:0] exp_q [$];
  logic [TRI_W-1:0] got_q [$];
  logic [31:0]      m_color = '1;
  logic [31:0]      m_uv    = '0;
  logic [1:0]       m_mode  = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [TRI_W-1:0] mk_tri(input logic [VTX_W-1:0] a, b, c);
    return {c, b, a};
  endfunction

  function automatic logic [POS_W-1:0] mkpos(input int i);
    return {25'(i + 300), 16'(i + 200), 16'(32'h1000 + i)};
  endfunction

  function automatic logic [15:0] tx(input logic [TRI_W-1:0] t, input int vi);
    return t[vi*VTX_W +: 16];
  endfunction

  function automatic logic [31:0] tcol(input logic [TRI_W-1:0] t, input int vi);
    return t[vi*VTX_W + POS_W +: 32];
  endfunction

  function automatic int model_vtx_count();
    if (m_mode == 2'd1 || m_mode == 2'd2) return (vlist.size() > 2) ? 2 : vlist.size();
    return vlist.size();
  endfunction

  // Reference: keep every vertex since the last restart and derive triangles by index.
  task automatic model_step();
    logic acc, pop;
    logic [VTX_W-1:0] v;
    int n, k;
    if (rst) begin
      vlist.delete(); exp_q.delete();
      m_color = '1; m_uv = '0; m_mode = '0;
      return;
    end
    acc = bus.vtx_valid && (exp_q.size() != OUT_DEPTH);
    pop = (exp_q.size() != 0) && bus.tri_ready;
    v   = {m_uv, m_color, bus.vtx_pos};
    if (pop) void'(exp_q.pop_front());
    if (bus.restart || bus.mode_we) begin
      vlist.delete();
      if (acc) vlist.push_back(v);
      if (bus.mode_we) m_mode = bus.mode_data;
    end else if (acc) begin
      vlist.push_back(v);
      n = vlist.size();
      if (m_mode == 2'd1) begin
        if (n >= 3) begin
          k = n - 3;
          if (k % 2 == 1) exp_q.push_back(mk_tri(vlist[k+1], vlist[k], vlist[k+2]));
          else            exp_q.push_back(mk_tri(vlist[k], vlist[k+1], vlist[k+2]));
        end
      end else if (m_mode == 2'd2) begin
        if (n >= 3) exp_q.push_back(mk_tri(vlist[0], vlist[n-2], vlist[n-1]));
      end else if (n == 3) begin
        exp_q.push_back(mk_tri(vlist[0], vlist[1], vlist[2]));
        vlist.delete();
      end
    end
    if (bus.color_we) m_color = bus.color_data;
    if (bus.uv_we)    m_uv    = bus.uv_data;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // Per-cycle compare, one time unit before the active edge.
  initial forever begin
    @(negedge clk);
    #4;
    if (!rst) begin
      chk("tri_valid", bus.tri_valid, exp_q.size() != 0);
      chk("out_count", bus.out_count, exp_q.size());
      chk("vtx_ready", bus.vtx_ready, exp_q.size() != OUT_DEPTH);
      chk("vtx_count", bus.vtx_count, model_vtx_count());
      chk("busy", bus.busy, (exp_q.size() != 0) || (model_vtx_count() != 0));
      if (bus.tri_valid && exp_q.size() != 0) begin
        checks++;
        if (bus.tri_vtx !== exp_q[0]) begin
          errors++;
          $display("FAIL tri_vtx: got %h expected %h", bus.tri_vtx, exp_q[0]);
        end
        if (bus.tri_ready) got_q.push_back(bus.tri_vtx);
      end
    end
  end

  task automatic put_vtx(input int idx, input bit cwe = 1'b0, input logic [31:0] c = 32'h0);
    int t = 0;
    @(negedge clk);
    bus.vtx_valid = 1'b1; bus.vtx_pos = mkpos(idx);
    bus.color_we = cwe; bus.color_data = c;
    while (!bus.vtx_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) chk("vtx_accept_timeout", 64'd0, 64'd1);
    @(negedge clk);
    bus.vtx_valid = 1'b0; bus.color_we = 1'b0;
  endtask

  task automatic set_color(input logic [31:0] c);
    @(negedge clk); bus.color_we = 1'b1; bus.color_data = c;
    @(negedge clk); bus.color_we = 1'b0;
  endtask

  task automatic set_mode(input logic [1:0] m);
    @(negedge clk); bus.mode_we = 1'b1; bus.mode_data = m;
    @(negedge clk); bus.mode_we = 1'b0;
  endtask

  task automatic pulse_restart();
    @(negedge clk); bus.restart = 1'b1;
    @(negedge clk); bus.restart = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (bus.out_count != 0 && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int acc_n, stalled, stall_cnt;
    bus.color_we = 0; bus.color_data = '0; bus.uv_we = 0; bus.uv_data = '0;
    bus.mode_we = 0; bus.mode_data = '0; bus.restart = 0;
    bus.vtx_valid = 0; bus.vtx_pos = '0; bus.tri_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_tri_valid", bus.tri_valid, 64'd0);
    chk("rst_tri_vtx_zero", bus.tri_vtx == '0, 64'd1);
    chk("rst_vtx_ready", bus.vtx_ready, 64'd1);
    chk("rst_busy", bus.busy, 64'd0);
    chk("rst_out_count", bus.out_count, 64'd0);

    // LIST with per-vertex colours
    got_q.delete();
    set_mode(2'd0);
    for (int i = 0; i < 6; i++) begin
      set_color(32'hC0C0_0000 + i);
      put_vtx(i);
    end
    drain();
    chk("list_ntri", got_q.size(), 64'd2);
    if (got_q.size() == 2) begin
      chk("list_t0_v0_col", tcol(got_q[0], 0), 64'hC0C0_0000);
      chk("list_t0_v2_col", tcol(got_q[0], 2), 64'hC0C0_0002);
      chk("list_t1_v0_x", tx(got_q[1], 0), 64'h1003);
      chk("list_t1_v2_col", tcol(got_q[1], 2), 64'hC0C0_0005);
    end
    chk("list_vtx_count", bus.vtx_count, 64'd0);

    // STRIP: (10,11,12),(12,11,13),(12,13,14)
    got_q.delete();
    set_mode(2'd1);
    for (int i = 10; i < 15; i++) put_vtx(i);
    drain();
    chk("strip_ntri", got_q.size(), 64'd3);
    if (got_q.size() == 3) begin
      chk("strip_t1_v0", tx(got_q[1], 0), 64'h100C);
      chk("strip_t1_v1", tx(got_q[1], 1), 64'h100B);
      chk("strip_t1_v2", tx(got_q[1], 2), 64'h100D);
      chk("strip_t2_v0", tx(got_q[2], 0), 64'h100C);
      chk("strip_t2_v2", tx(got_q[2], 2), 64'h100E);
    end
    chk("strip_vtx_count", bus.vtx_count, 64'd2);

    // FAN: (20,21,22),(20,22,23),(20,23,24)
    got_q.delete();
    set_mode(2'd2);
    for (int i = 20; i < 25; i++) put_vtx(i);
    drain();
    chk("fan_ntri", got_q.size(), 64'd3);
    if (got_q.size() == 3) begin
      chk("fan_t1_v0", tx(got_q[1], 0), 64'h1014);
      chk("fan_t1_v1", tx(got_q[1], 1), 64'h1016);
      chk("fan_t2_v1", tx(got_q[2], 1), 64'h1017);
      chk("fan_t2_v2", tx(got_q[2], 2), 64'h1018);
    end

    // Backpressure: 15 LIST vertices against a stalled rasterizer
    got_q.delete();
    set_mode(2'd0);
    bus.tri_ready = 1'b0;
    acc_n = 0; stalled = -1; stall_cnt = -1;
    for (int c = 0; c < 80 && acc_n < 15; c++) begin
      @(negedge clk);
      bus.vtx_valid = 1'b1; bus.vtx_pos = mkpos(30 + acc_n);
      if (c == 25) bus.tri_ready = 1'b1;
      if (bus.vtx_ready) acc_n++;
      else if (stalled < 0) begin stalled = acc_n; stall_cnt = int'(bus.out_count); end
    end
    @(negedge clk); bus.vtx_valid = 1'b0;
    chk("bp_accepted", acc_n, 64'd15);
    chk("bp_stall_after", stalled, 64'd12);
    chk("bp_out_count_full", stall_cnt, 64'd4);
    drain();
    chk("bp_ntri", got_q.size(), 64'd5);
    if (got_q.size() == 5) begin
      chk("bp_t0_v0", tx(got_q[0], 0), 64'h101E);
      chk("bp_t4_v2", tx(got_q[4], 2), 64'h102C);
    end

    // Restart discards the partial primitive
    got_q.delete();
    put_vtx(40); put_vtx(41);
    pulse_restart();
    put_vtx(42); put_vtx(43); put_vtx(44);
    drain();
    chk("restart_ntri", got_q.size(), 64'd1);
    if (got_q.size() == 1) begin
      chk("restart_v0", tx(got_q[0], 0), 64'h102A);
      chk("restart_v2", tx(got_q[0], 2), 64'h102C);
    end

    // Same-cycle colour write applies to the following vertex
    got_q.delete();
    set_color(32'hAABBCCDD);
    pulse_restart();
    put_vtx(50, 1'b1, 32'h11223344);
    put_vtx(51); put_vtx(52);
    drain();
    chk("col_ntri", got_q.size(), 64'd1);
    if (got_q.size() == 1) begin
      chk("col_v0_old", tcol(got_q[0], 0), 64'hAABBCCDD);
      chk("col_v1_new", tcol(got_q[0], 1), 64'h11223344);
    end

    // Reset mid-strip
    set_mode(2'd1);
    bus.tri_ready = 1'b0;
    put_vtx(60); put_vtx(61); put_vtx(62);
    chk("pre_rst_out_count", bus.out_count, 64'd1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("mid_rst_tri_valid", bus.tri_valid, 64'd0);
    chk("mid_rst_out_count", bus.out_count, 64'd0);
    chk("mid_rst_vtx_count", bus.vtx_count, 64'd0);
    got_q.delete();
    bus.tri_ready = 1'b1;
    put_vtx(70); put_vtx(71); put_vtx(72);
    drain();
    chk("post_rst_ntri", got_q.size(), 64'd1);
    if (got_q.size() == 1) begin
      chk("post_rst_col", tcol(got_q[0], 0), 64'hFFFFFFFF);
      chk("post_rst_v0", tx(got_q[0], 0), 64'h1046);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end
endmodule
